psk8_frame_mapper: RTL and testbench
====================================

PSK8_FRAME_MAPPER -- requirements
Module: psk8_frame_mapper

Interface
REQ-001 Parameter IQ_W, default 12: signed I/Q output width; AMP = 2^(IQ_W-1)-1.
REQ-002 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-003 Port reset_b, input, 1: reset, asynchronous, active-low.
REQ-004 Port din, input, 324: RS-encoded frame, 54 six-bit codeword symbols.
REQ-005 Port ena_in, input, 1: one-cycle strobe; din is valid in this cycle.
REQ-006 Port out_valid, output, 1: sym, i_out, q_out, sof and eof are valid.
REQ-007 Port out_ready, input, 1: downstream accepts; a transfer is out_valid & out_ready.
REQ-008 Port sym, output, 3: raw tribit of the current symbol.
REQ-009 Ports i_out and q_out, output, IQ_W each, signed: constellation point.
REQ-010 Ports sof and eof, output, 1 each: first and last symbol of a frame; qualified by out_valid.
REQ-011 Port overflow, output, 1: one-cycle pulse when a frame is dropped.
REQ-012 Port busy, output, 1: high while any frame is active or pending.

Function
REQ-013 The block SHALL hold two frame registers: active (being serialised) and pending (one-deep skid).
REQ-014 Each frame SHALL produce 108 symbols, k=0..107, in ascending order; symbol k = {din[3k+2], din[3k+1], din[3k]}.
REQ-015 When idle, ena_in at cycle N SHALL load active directly and assert out_valid with sof at cycle N+1, carrying symbol 0.
REQ-016 While active is busy and pending is empty, ena_in SHALL load pending.
REQ-017 While pending is full, ena_in SHALL discard din and pulse overflow for one cycle; active and pending are unchanged.
REQ-018 Exception to REQ-017: if ena_in coincides with the transfer of eof, pending SHALL move to active and the new din SHALL load pending, with no overflow.
REQ-019 If ena_in coincides with the eof transfer and pending is empty, din SHALL load active directly; symbol 0 follows the next cycle with no gap.
REQ-020 After the eof transfer with pending full, the next cycle SHALL present symbol 0 of the pending frame (no bubble); otherwise out_valid SHALL drop.
REQ-021 While out_valid & ~out_ready, all outputs SHALL hold stable.
REQ-022 The symbol counter SHALL be 7-bit, range 0..107, and SHALL wrap to 0 only on the eof transfer.
REQ-023 Mapping: phase index p gives I = round(AMP*cos(p*45°)) and Q = round(AMP*sin(p*45°)).
REQ-024 With IQ_W=12 the points SHALL be p0..p7 = (2047,0), (1447,1447), (0,2047), (-1447,1447), (-2047,0), (-1447,-1447), (0,-2047), (1447,-1447).
REQ-025 busy SHALL equal out_valid | pending_full.

Reset
REQ-026 On reset_b low, out_valid, sof, eof, overflow, busy, sym, i_out, q_out, the counter and both full flags SHALL clear to 0 immediately.
REQ-027 Reset mid-frame SHALL discard active and pending frames; the first ena_in after release SHALL restart at symbol 0.

Configuration
REQ-028 Macro PSK8_GRAY_EN defined: p SHALL be the Gray-decoded tribit, i.e. sym 000,001,011,010,110,111,101,100 give p = 0..7.
REQ-029 Macro PSK8_GRAY_EN undefined: p SHALL equal sym (natural mapping); all timing is identical.

Structure
REQ-030 Package psk8_pkg SHALL hold FRAME_W=324, SYMS_PER_FRAME=108, the Gray decode table and the cos/sin point function.
REQ-031 The tribit-to-I/Q mapping SHALL be a combinational sub-module psk8_lut, with outputs registered in psk8_frame_mapper.

Verification
REQ-032 din = 324'h0 with bit 0 set, one ena_in, out_ready=1 -> 108 symbols; symbol 0 is sym=001 (I=1447, Q=1447 natural), sof and eof one cycle each; symbol 107 is (2047,0).
REQ-033 Two ena_in 10 cycles apart, out_ready=1 -> 216 contiguous valid cycles, no overflow, second sof immediately after first eof.
REQ-034 Three ena_in in consecutive cycles -> third frame dropped, overflow pulses once, exactly 216 symbols out.
REQ-035 out_ready toggled by a random 50% pattern -> outputs stable during stalls; symbol sequence identical to the ready=1 run.
REQ-036 reset_b low at symbol 40 -> all outputs 0 immediately; a new ena_in yields sof with symbol 0 one cycle later.
REQ-037 Build with PSK8_GRAY_EN, sym=010 -> (-1447,1447); without it -> (0,2047).

Source files
------------

// File: rtl/psk8_pkg.sv
// Shared constants, Gray decode table and constellation point function for the 8-PSK frame mapper.
package psk8_pkg;

   localparam int unsigned FRAME_W        = 324;
   localparam int unsigned SYMS_PER_FRAME = 108;
   localparam int unsigned SYM_W          = 3;
   localparam int unsigned CNT_W          = 7;

   // Indexed by the received tribit; yields the phase index p.
   localparam logic [2:0] GRAY_DEC [8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd7, 3'd6, 3'd4, 3'd5};

   typedef struct packed {
      logic signed [31:0] i;
      logic signed [31:0] q;
   } iq_pt_t;

   // Point p*45 deg on a circle of radius 2^(iq_w-1)-1; 46341/65536 approximates 1/sqrt(2).
   function automatic iq_pt_t psk8_point(input logic [2:0] p, input int unsigned iq_w);
      logic signed [63:0] amp;
      logic signed [63:0] diag;
      logic signed [31:0] a;
      logic signed [31:0] d;
      iq_pt_t             pt;
      amp  = (64'sd1 <<< (iq_w - 1)) - 64'sd1;
      diag = (amp * 64'sd46341 + 64'sd32768) >>> 16;
      a    = 32'(amp);
      d    = 32'(diag);
      pt   = '{i: 32'sd0, q: 32'sd0};
      case (p)
         3'd0: pt = '{i:  a, q: 32'sd0};
         3'd1: pt = '{i:  d, q:  d};
         3'd2: pt = '{i: 32'sd0, q:  a};
         3'd3: pt = '{i: -d, q:  d};
         3'd4: pt = '{i: -a, q: 32'sd0};
         3'd5: pt = '{i: -d, q: -d};
         3'd6: pt = '{i: 32'sd0, q: -a};
         3'd7: pt = '{i:  d, q: -d};
      endcase
      return pt;
   endfunction

endpackage

// File: rtl/psk8_lut.sv
// Combinational tribit to 8-PSK I/Q mapping; PSK8_GRAY_EN selects Gray-decoded phase.
module psk8_lut
   import psk8_pkg::*;
#(
   parameter int unsigned IQ_W = 12
) (
   input  logic [SYM_W-1:0]       sym,
   output logic signed [IQ_W-1:0] i_c,
   output logic signed [IQ_W-1:0] q_c
);

   logic [2:0] p;
   iq_pt_t     pt;

   always_comb begin
`ifdef PSK8_GRAY_EN
      p = GRAY_DEC[sym];
`else
      p = sym;
`endif
      pt  = psk8_point(p, IQ_W);
      i_c = IQ_W'(pt.i);
      q_c = IQ_W'(pt.q);
   end

endmodule

// File: rtl/psk8_frame_mapper.sv
// Serialises 324-bit frames into 108 registered 8-PSK symbols with a one-deep pending frame.
// Build option: PSK8_GRAY_EN selects Gray-coded phase mapping (natural mapping otherwise).
module psk8_frame_mapper
   import psk8_pkg::*;
#(
   parameter int unsigned IQ_W = 12
) (
   input  logic                   clk,
   input  logic                   reset_b,
   input  logic [FRAME_W-1:0]     din,
   input  logic                   ena_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [SYM_W-1:0]       sym,
   output logic signed [IQ_W-1:0] i_out,
   output logic signed [IQ_W-1:0] q_out,
   output logic                   sof,
   output logic                   eof,
   output logic                   overflow,
   output logic                   busy
);

   localparam int unsigned       IDX_W    = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(SYMS_PER_FRAME - 1);

   logic [FRAME_W-1:0]     active_q, active_n;
   logic [FRAME_W-1:0]     pending_q, pending_n;
   logic [FRAME_W-1:0]     start_frame;
   logic                   pending_full_q, pending_full_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n, cnt_inc;
   logic [IDX_W-1:0]       bit_idx;
   logic [SYM_W-1:0]       sym_n;
   logic signed [IQ_W-1:0] lut_i, lut_q;
   logic                   valid_n, sof_n, eof_n, ovf_n;
   logic                   load_sym, start, xfer, last;

   assign xfer    = out_valid & out_ready;
   assign last    = xfer & (cnt_q == LAST_IDX);
   assign cnt_inc = cnt_q + CNT_W'(1);
   assign bit_idx = IDX_W'(cnt_inc) * IDX_W'(3);

   // Frame admission, symbol advance and handover between active and pending.
   always_comb begin
      active_n       = active_q;
      pending_n      = pending_q;
      pending_full_n = pending_full_q;
      valid_n        = out_valid;
      cnt_n          = cnt_q;
      sof_n          = sof;
      eof_n          = eof;
      ovf_n          = 1'b0;
      sym_n          = sym;
      load_sym       = 1'b0;
      start          = 1'b0;
      start_frame    = din;

      if (last) begin
         if (pending_full_q) begin
            start          = 1'b1;
            start_frame    = pending_q;
            pending_n      = din;
            pending_full_n = ena_in;
         end else if (ena_in) begin
            start = 1'b1;
         end else begin
            valid_n = 1'b0;
            cnt_n   = '0;
            sof_n   = 1'b0;
            eof_n   = 1'b0;
         end
      end else begin
         if (xfer) begin
            cnt_n    = cnt_inc;
            sym_n    = active_q[bit_idx +: SYM_W];
            load_sym = 1'b1;
            sof_n    = 1'b0;
            eof_n    = (cnt_inc == LAST_IDX);
         end
         if (ena_in) begin
            if (!out_valid) begin
               start = 1'b1;
            end else if (!pending_full_q) begin
               pending_n      = din;
               pending_full_n = 1'b1;
            end else begin
               ovf_n = 1'b1;
            end
         end
      end

      if (start) begin
         active_n = start_frame;
         cnt_n    = '0;
         sym_n    = start_frame[SYM_W-1:0];
         load_sym = 1'b1;
         valid_n  = 1'b1;
         sof_n    = 1'b1;
         eof_n    = 1'b0;
      end
   end

   psk8_lut #(.IQ_W(IQ_W)) u_lut (
      .sym (sym_n),
      .i_c (lut_i),
      .q_c (lut_q)
   );

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         out_valid      <= 1'b0;
         sof            <= 1'b0;
         eof            <= 1'b0;
         overflow       <= 1'b0;
         busy           <= 1'b0;
         sym            <= '0;
         i_out          <= '0;
         q_out          <= '0;
         cnt_q          <= '0;
         pending_full_q <= 1'b0;
      end else begin
         out_valid      <= valid_n;
         sof            <= sof_n;
         eof            <= eof_n;
         overflow       <= ovf_n;
         busy           <= valid_n | pending_full_n;
         cnt_q          <= cnt_n;
         pending_full_q <= pending_full_n;
         if (load_sym) begin
            sym   <= sym_n;
            i_out <= lut_i;
            q_out <= lut_q;
         end
      end
   end

   // Frame payloads are qualified by the flags above, so they carry no reset.
   always_ff @(posedge clk) begin
      active_q  <= active_n;
      pending_q <= pending_n;
   end

endmodule

// File: tb/tb_psk8_frame_mapper.sv
// Bench for psk8_frame_mapper: frame-queue reference model, random data and ready, directed scenarios.
module tb_psk8_frame_mapper;
   import psk8_pkg::*;

   localparam int unsigned IQ_W = 12;
   localparam int          LAST = int'(SYMS_PER_FRAME) - 1;

   logic                   clk = 1'b0;
   logic                   reset_b;
   logic [FRAME_W-1:0]     din;
   logic                   ena_in;
   logic                   out_valid;
   logic                   out_ready;
   logic [SYM_W-1:0]       sym;
   logic signed [IQ_W-1:0] i_out;
   logic signed [IQ_W-1:0] q_out;
   logic                   sof, eof, overflow, busy;

   int total = 0;
   int bad   = 0;

   // Reference model: frames accepted but not fully transferred, and position inside the head frame.
   logic [FRAME_W-1:0] mq[$];
   int                 midx    = 0;
   bit                 exp_ovf = 1'b0;
   int                 n_xfer, n_sof, n_eof, n_ovf;

   psk8_frame_mapper #(.IQ_W(IQ_W)) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .din       (din),
      .ena_in    (ena_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sym       (sym),
      .i_out     (i_out),
      .q_out     (q_out),
      .sof       (sof),
      .eof       (eof),
      .overflow  (overflow),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int phase_of(input logic [2:0] s);
`ifdef PSK8_GRAY_EN
      for (int p = 0; p < 8; p++)
         if (3'(p ^ (p >> 1)) == s) return p;
      return 0;
`else
      return int'(s);
`endif
   endfunction

   function automatic int ref_coord(input int p, input bit is_q);
      real a, ang, x;
      a   = real'((1 << (IQ_W - 1)) - 1);
      ang = real'(p) * 3.14159265358979323846 / 4.0;
      x   = is_q ? a * $sin(ang) : a * $cos(ang);
      return (x >= 0.0) ? $rtoi($floor(x + 0.5)) : -$rtoi($floor(-x + 0.5));
   endfunction

   function automatic logic [FRAME_W-1:0] rand_frame();
      logic [FRAME_W-1:0] f;
      for (int b = 0; b < int'(FRAME_W); b++) f[b] = 1'($urandom);
      return f;
   endfunction

   task automatic model_step(input bit e, input logic [FRAME_W-1:0] d, input bit r);
      bit v, x, l;
      v = mq.size() > 0;
      x = v && r;
      l = x && (midx == LAST);
      exp_ovf = 1'b0;
      if (e) begin
         if (mq.size() < 2 || l) mq.push_back(d);
         else exp_ovf = 1'b1;
      end
      if (x) begin
         if (l) begin
            void'(mq.pop_front());
            midx = 0;
         end else begin
            midx++;
         end
      end
   endtask

   task automatic check_outputs();
      logic [FRAME_W-1:0] f;
      logic [2:0]         s;
      bit                 v;
      v = mq.size() > 0;
      chk("out_valid", out_valid, v);
      chk("busy", busy, v);
      chk("overflow", overflow, exp_ovf);
      if (v) begin
         f = mq[0];
         s = f[3*midx +: 3];
         chk("sym", sym, s);
         chk("i_out", i_out, ref_coord(phase_of(s), 1'b0));
         chk("q_out", q_out, ref_coord(phase_of(s), 1'b1));
         chk("sof", sof, midx == 0);
         chk("eof", eof, midx == LAST);
      end
   endtask

   // One clock: inputs already driven at the falling edge; sample and check at the next falling edge.
   task automatic cycle();
      logic [FRAME_W-1:0] d;
      bit e, r;
      e = ena_in;
      d = din;
      r = out_ready;
      if (out_valid && r) begin
         n_xfer++;
         if (sof) n_sof++;
         if (eof) n_eof++;
      end
      @(posedge clk);
      @(negedge clk);
      model_step(e, d, r);
      check_outputs();
      if (overflow) n_ovf++;
      ena_in = 1'b0;
   endtask

   task automatic clr_counts();
      n_xfer = 0; n_sof = 0; n_eof = 0; n_ovf = 0;
   endtask

   task automatic send(input logic [FRAME_W-1:0] f);
      din    = f;
      ena_in = 1'b1;
      cycle();
   endtask

   task automatic run(input int n, input int p_ena, input int p_rdy, input bit on_eof);
      for (int k = 0; k < n; k++) begin
         out_ready = (int'($urandom_range(99)) < p_rdy);
         din       = rand_frame();
         ena_in    = (int'($urandom_range(99)) < p_ena) ||
                     (on_eof && out_ready && mq.size() > 0 && midx == LAST);
         cycle();
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 500 && mq.size() > 0; k++) begin
         out_ready = 1'b1;
         ena_in    = 1'b0;
         cycle();
      end
      chk("drain_empty", mq.size(), 0);
      chk("drain_busy", busy, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_sof"}, sof, 0);
      chk({tag, "_eof"}, eof, 0);
      chk({tag, "_ovf"}, overflow, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_sym"}, sym, 0);
      chk({tag, "_i"}, i_out, 0);
      chk({tag, "_q"}, q_out, 0);
   endtask

   initial begin
      logic [FRAME_W-1:0] f;
      reset_b   = 1'b0;
      ena_in    = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      clr_counts();
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      reset_b = 1'b1;
      cycle();

      // Single frame with only bit 0 set.
      clr_counts();
      out_ready = 1'b1;
      f    = '0;
      f[0] = 1'b1;
      send(f);
      chk("single_sym0", sym, 1);
      chk("single_i0", i_out, 1447);
      chk("single_q0", q_out, 1447);
      chk("single_sof0", sof, 1);
      drain();
      chk("single_xfer", n_xfer, 108);
      chk("single_sof_cnt", n_sof, 1);
      chk("single_eof_cnt", n_eof, 1);

      // Two frames ten cycles apart, back-to-back output.
      clr_counts();
      send(rand_frame());
      repeat (9) cycle();
      send(rand_frame());
      drain();
      chk("two_xfer", n_xfer, 216);
      chk("two_ovf", n_ovf, 0);
      chk("two_sof_cnt", n_sof, 2);

      // Three consecutive strobes: third frame dropped.
      clr_counts();
      send(rand_frame());
      send(rand_frame());
      send(rand_frame());
      drain();
      chk("three_xfer", n_xfer, 216);
      chk("three_ovf", n_ovf, 1);

      // Random 50% ready with sparse random strobes.
      clr_counts();
      send(rand_frame());
      send(rand_frame());
      run(700, 1, 50, 1'b0);
      drain();
      chk("rand_eof_vs_sof", n_eof, n_sof);

      // Strobe coinciding with eof transfer, pending empty then pending full.
      clr_counts();
      send(rand_frame());
      run(120, 0, 100, 1'b1);
      send(rand_frame());
      run(250, 0, 100, 1'b1);
      drain();
      chk("eof_hit_ovf", n_ovf, 0);

      // Reset mid-frame with a pending frame held.
      clr_counts();
      send(rand_frame());
      send(rand_frame());
      for (int k = 0; k < 80 && midx != 40; k++) begin
         out_ready = 1'b1;
         cycle();
      end
      chk("reach_sym40", midx, 40);
      reset_b = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clk);
      reset_b = 1'b1;
      mq.delete();
      midx    = 0;
      exp_ovf = 1'b0;
      cycle();
      cycle();
      f = rand_frame();
      send(f);
      chk("restart_sof", sof, 1);
      chk("restart_sym", sym, f[2:0]);
      drain();

      // Phase mapping of tribit 010.
      f    = '0;
      f[1] = 1'b1;
      send(f);
`ifdef PSK8_GRAY_EN
      chk("map010_i", i_out, -1447);
      chk("map010_q", q_out, 1447);
`else
      chk("map010_i", i_out, 0);
      chk("map010_q", q_out, 2047);
`endif
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
